// File: rtl/tilemap_render.sv
// Tile-map VGA renderer: 4-stage pipeline from pixel row/col to palette RGB.
// Ports: clk, reset (sync, low), row/col/HS/VS/blank in, tile map and
// pattern ROM read ports, palette write port, VGA RGB/sync out.
// Option: TILEMAP_SCROLL_EN adds scroll_x/scroll_y, latched on raw VS rise.
module tilemap_render #(
  parameter int MAP_COLS = 80,
  parameter int LATENCY  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  row,
  input  logic [9:0]  col,
  input  logic        HS,
  input  logic        VS,
  input  logic        blank,
  output logic [12:0] tmap_addr,
  input  logic [7:0]  tmap_data,
  output logic [13:0] pat_addr,
  input  logic [1:0]  pat_data,
  input  logic        pal_we,
  input  logic [1:0]  pal_idx,
  input  logic [23:0] pal_data,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N
`ifdef TILEMAP_SCROLL_EN
  ,
  input  logic [9:0]  scroll_x,
  input  logic [8:0]  scroll_y
`endif
);

  logic [9:0] x;
  logic [8:0] y;

`ifdef TILEMAP_SCROLL_EN
  logic [9:0]  sx_sh;
  logic [8:0]  sy_sh;
  logic        vs_q;
  logic [10:0] xs;
  logic [9:0]  ys;

  // Shadows only move on a raw VS rise so a frame never tears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sx_sh <= '0;
      sy_sh <= '0;
      vs_q  <= 1'b0;
    end else begin
      vs_q <= VS;
      if (VS && !vs_q) begin
        sx_sh <= (scroll_x > 10'd639) ? 10'd0 : scroll_x;
        sy_sh <= (scroll_y > 9'd479) ? 9'd0 : scroll_y;
      end
    end
  end

  always_comb begin
    xs = {1'b0, col} + {1'b0, sx_sh};
    ys = {1'b0, row} + {1'b0, sy_sh};
    x  = (xs >= 11'd640) ? 10'(xs - 11'd640) : xs[9:0];
    y  = (ys >= 10'd480) ? 9'(ys - 10'd480) : ys[8:0];
  end
`else
  assign x = col;
  assign y = row;
`endif

  logic [2:0]  fx1, fy1;
  logic [23:0] color3;
  logic [23:0] pal [4];
  logic [LATENCY-2:0] hs_d, vs_d, bl_d;

  // S1: tile map address and fine offsets.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmap_addr <= '0;
      fx1       <= '0;
      fy1       <= '0;
    end else begin
      tmap_addr <= 13'(y[8:3]) * 13'(MAP_COLS) + 13'(x[9:3]);
      fx1       <= x[2:0];
      fy1       <= y[2:0];
    end
  end

  // S2: pattern ROM address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_addr <= '0;
    end else begin
      pat_addr <= {tmap_data, fy1, fx1};
    end
  end

  // Palette: a read in the write cycle sees the old entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pal[0] <= 24'h000000;
      pal[1] <= 24'hFF0000;
      pal[2] <= 24'h00FF00;
      pal[3] <= 24'h0000FF;
    end else if (pal_we) begin
      pal[pal_idx] <= pal_data;
    end
  end

  // S3: palette lookup.
  always_ff @(posedge clk) begin
    if (!reset) begin
      color3 <= '0;
    end else begin
      color3 <= pal[pat_data];
    end
  end

  // Syncs ride alongside S1..S3, then S4 registers them out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_d <= '0;
      vs_d <= '0;
      bl_d <= '0;
    end else begin
      hs_d <= {hs_d[LATENCY-3:0], HS};
      vs_d <= {vs_d[LATENCY-3:0], VS};
      bl_d <= {bl_d[LATENCY-3:0], blank};
    end
  end

  // S4: outputs, colour forced black while blanked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b0;
      VGA_VS      <= 1'b0;
      VGA_BLANK_N <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= bl_d[LATENCY-2] ? 24'd0 : color3;
      VGA_HS      <= hs_d[LATENCY-2];
      VGA_VS      <= vs_d[LATENCY-2];
      VGA_BLANK_N <= ~bl_d[LATENCY-2];
    end
  end

endmodule

// File: tb/tb_tilemap_render.sv
// Scoreboard bench for tilemap_render: directed pixels, palette write,
// sync delay, mid-line reset, and scroll when TILEMAP_SCROLL_EN is set.
module tb_tilemap_render;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  row = '0;
  logic [9:0]  col = '0;
  logic        HS = 1'b0, VS = 1'b0, blank = 1'b1;
  logic [12:0] tmap_addr;
  logic [7:0]  tmap_data;
  logic [13:0] pat_addr;
  logic [1:0]  pat_data;
  logic        pal_we = 1'b0;
  logic [1:0]  pal_idx = '0;
  logic [23:0] pal_data = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;
`ifdef TILEMAP_SCROLL_EN
  logic [9:0]  scroll_x = '0;
  logic [8:0]  scroll_y = '0;
`endif

  tilemap_render dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .HS(HS), .VS(VS), .blank(blank),
    .tmap_addr(tmap_addr), .tmap_data(tmap_data),
    .pat_addr(pat_addr), .pat_data(pat_data),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N)
`ifdef TILEMAP_SCROLL_EN
    , .scroll_x(scroll_x), .scroll_y(scroll_y)
`endif
  );

  // Memory models: tile = addr*3+2, palette index = pattern addr[1:0].
  assign tmap_data = 8'(tmap_addr * 3 + 2);
  assign pat_data  = pat_addr[1:0];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] v;
  } item_t;

  item_t q [3][$];
  int n_vec = 0;
  int n_err = 0;
  string qname [3] = '{"tmap_addr", "pat_addr", "video"};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] act_of(input int k);
    case (k)
      0:       return 32'(tmap_addr);
      1:       return 32'(pat_addr);
      default: return {5'd0, VGA_BLANK_N, VGA_HS, VGA_VS,
                       VGA_R, VGA_G, VGA_B};
    endcase
  endfunction

  // Monitor: pop every item due this cycle and compare.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        while (q[k].size() > 0 && q[k][0].due <= cyc) begin
          it = q[k].pop_front();
          if (it.due < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL %s stale: due %0d now %0d",
                     qname[k], it.due, cyc);
          end else begin
            chk(qname[k], act_of(k), it.v);
          end
        end
      end
    end
  end

  task automatic apply(input logic [8:0] r, input logic [9:0] c,
                       input logic h, input logic v, input logic b,
                       input logic ca, input logic [12:0] ta,
                       input logic [13:0] pa, input logic [23:0] rgb);
    item_t it;
    @(negedge clk);
    row = r; col = c; HS = h; VS = v; blank = b;
    if (ca) begin
      it.due = cyc + 1; it.v = 32'(ta); q[0].push_back(it);
      it.due = cyc + 2; it.v = 32'(pa); q[1].push_back(it);
    end
    it.due = cyc + 4;
    it.v = {5'd0, ~b, h, v, (b ? 24'd0 : rgb)};
    q[2].push_back(it);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rgb"}, {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    chk({tag, "_sync"}, {30'd0, VGA_HS, VGA_VS}, 32'd0);
    chk({tag, "_blank_n"}, 32'(VGA_BLANK_N), 32'd0);
    chk({tag, "_tmap"}, 32'(tmap_addr), 32'd0);
    chk({tag, "_pat"}, 32'(pat_addr), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if ((q[0].size() + q[1].size() + q[2].size()) > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain timeout: %0d items left",
               q[0].size() + q[1].size() + q[2].size());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    @(negedge clk);
    reset = 1'b1;

    apply(9'd0,   10'd9,   0, 0, 0, 1, 13'h0001, 14'h0141, 24'hFF0000);
    apply(9'd0,   10'd10,  1, 0, 0, 1, 13'h0001, 14'h0142, 24'h00FF00);
    apply(9'd0,   10'd10,  1, 1, 1, 1, 13'h0001, 14'h0142, 24'h00FF00);
    apply(9'd479, 10'd639, 0, 1, 0, 1, 13'h12BF, 14'h0FFF, 24'h0000FF);
    apply(9'd17,  10'd300, 1, 1, 0, 1, 13'h00C5, 14'h144C, 24'h000000);
    apply(9'd8,   10'd11,  0, 0, 0, 1, 13'h0051, 14'h3D43, 24'h0000FF);

    // Palette write lands on the edge where this pixel reads index 2.
    apply(9'd0,   10'd10,  0, 0, 0, 1, 13'h0001, 14'h0142, 24'h00FF00);
    fork
      begin
        repeat (2) @(negedge clk);
        pal_we = 1'b1; pal_idx = 2'd2; pal_data = 24'h123456;
        @(negedge clk);
        pal_we = 1'b0;
      end
    join_none
    apply(9'd0,   10'd10,  1, 0, 0, 1, 13'h0001, 14'h0142, 24'h123456);
    apply(9'd8,   10'd11,  0, 1, 0, 1, 13'h0051, 14'h3D43, 24'h0000FF);
    apply(9'd0,   10'd10,  1, 1, 0, 1, 13'h0001, 14'h0142, 24'h123456);
    drain();

    // One-cycle mid-line reset with syncs high.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset_checks("midrst");
    @(negedge clk);
    reset = 1'b1;
    apply(9'd0,   10'd10,  0, 0, 0, 1, 13'h0001, 14'h0142, 24'h00FF00);
    apply(9'd0,   10'd9,   1, 0, 0, 1, 13'h0001, 14'h0141, 24'hFF0000);
    drain();

`ifdef TILEMAP_SCROLL_EN
    scroll_x = 10'd636;
    scroll_y = 9'd8;
    apply(9'd0,   10'd0,   0, 0, 1, 0, 13'd0, 14'd0, 24'd0);
    apply(9'd0,   10'd0,   0, 1, 1, 0, 13'd0, 14'd0, 24'd0);
    apply(9'd479, 10'd10,  0, 1, 0, 1, 13'h0000, 14'h00BE, 24'h00FF00);
    scroll_x = 10'd700;
    scroll_y = 9'd500;
    apply(9'd479, 10'd10,  0, 1, 0, 1, 13'h0000, 14'h00BE, 24'h00FF00);
    apply(9'd0,   10'd0,   0, 0, 1, 0, 13'd0, 14'd0, 24'd0);
    apply(9'd0,   10'd0,   0, 1, 1, 0, 13'd0, 14'd0, 24'd0);
    apply(9'd479, 10'd10,  0, 1, 0, 1, 13'h1271, 14'h157A, 24'h00FF00);
    drain();
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
